// File: rtl/eeprom_i2c_slave_pkg.sv
// ----------------------------------------------------------------------------
// eeprom_i2c_slave_pkg
// Shared definitions for the I2C EEPROM responder.
//   - ADDR_W_DEF / DEV_ID_DEF : default geometry and device-type code
//   - state_e                 : one-hot protocol state encoding
//   - ctrl_match()            : device-type compare on a received control byte
// ----------------------------------------------------------------------------
package eeprom_i2c_slave_pkg;

  localparam int         ADDR_W_DEF = 11;
  localparam logic [3:0] DEV_ID_DEF = 4'b1010;

  typedef enum logic [8:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_CTRL      = 9'b0_0000_0010,
    ST_ACK_CTRL  = 9'b0_0000_0100,
    ST_ADDR      = 9'b0_0000_1000,
    ST_ACK_ADDR  = 9'b0_0001_0000,
    ST_WDATA     = 9'b0_0010_0000,
    ST_ACK_WDATA = 9'b0_0100_0000,
    ST_RDATA     = 9'b0_1000_0000,
    ST_RACK      = 9'b1_0000_0000
  } state_e;

  // Control byte layout: {device type[7:4], block select[3:1], R/W[0]}.
  function automatic logic ctrl_match(input logic [7:0] ctrl, input logic [3:0] dev_id);
    return ctrl[7:4] == dev_id;
  endfunction

endpackage

// File: rtl/eeprom_i2c_slave_if.sv
// ----------------------------------------------------------------------------
// eeprom_i2c_slave_if
// Two-wire bus between the EEPROM master and the responder.
//   scl       : serial clock, driven by the master
//   sda_m_low : master pulls SDA low when 1
//   sda_oe    : responder pulls SDA low when 1 (never drives high)
//   sda       : resolved open-drain line level (wired-AND with pull-up)
// At the board top the pad is built as  assign SDA = sda_oe ? 1'b0 : 1'bz;
// ----------------------------------------------------------------------------
interface eeprom_i2c_slave_if;

  logic scl;
  logic sda_m_low;
  logic sda_oe;
  logic sda;

  // Pull-up resistor: the line is high unless somebody pulls it down.
  assign sda = ~(sda_m_low | sda_oe);

  modport master (output scl, output sda_m_low, input sda, input sda_oe);
  modport slave  (input  scl, input  sda,       output sda_oe);

endinterface

// File: rtl/eeprom_i2c_slave_line_sync.sv
// ----------------------------------------------------------------------------
// eeprom_i2c_slave_line_sync
// Brings SCL/SDA into the clk domain and derives bus events.
//   clk, rst      : system clock, async active-high reset
//   scl_i, sda_i  : raw bus lines
//   sda_o         : synchronized SDA level
//   scl_rise_o    : one-clk pulse on SCL rising edge
//   scl_fall_o    : one-clk pulse on SCL falling edge
//   start_o       : SDA fell while SCL high
//   stop_o        : SDA rose while SCL high
// Events appear two clocks after the pin change.
// ----------------------------------------------------------------------------
module eeprom_i2c_slave_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0],[1]: two-flop synchronizer; [2]: previous synchronized value.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] &  scl_q[2];
  // SCL must be stable high across the SDA transition.
  assign start_o    =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_o     =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/eeprom_i2c_slave.sv
// ----------------------------------------------------------------------------
// eeprom_i2c_slave
// 24C16-style I2C EEPROM responder, 2**ADDR_W bytes.
// Byte/sequential write, current-address read, random read (repeated START).
//   clk, rst     : system clock (>= 8 clk per SCL period), async active-high reset
//   bus          : SCL/SDA open-drain pair (slave modport)
//   busy_o       : high from matched control-byte ACK until STOP/NACK/IDLE
//   wr_pulse_o   : one-clk pulse per byte committed to memory
//   addr_ptr_o   : current internal address pointer
// ADDR_W must lie in 9..11: the block-select bits ctrl[3:1] supply the
// upper ADDR_W-8 address bits.
// ----------------------------------------------------------------------------
module eeprom_i2c_slave
  import eeprom_i2c_slave_pkg::*;
#(
  parameter int         ADDR_W = ADDR_W_DEF,
  parameter logic [3:0] DEV_ID = DEV_ID_DEF
) (
  input  logic              clk,
  input  logic              rst,
  eeprom_i2c_slave_if.slave bus,
  output logic              busy_o,
  output logic              wr_pulse_o,
  output logic [ADDR_W-1:0] addr_ptr_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HI_W  = ADDR_W - 8;

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  eeprom_i2c_slave_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (bus.scl),
    .sda_i      (bus.sda),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              sda_oe_q;
  logic              busy_q;
  logic              rw_q;
  logic              wr_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] addr_ptr_q;

  logic [7:0]        mem [0:DEPTH-1];

  logic [7:0]        shift_in;
  logic [ADDR_W-1:0] addr_inc;

  assign shift_in = {shift_q[6:0], sda_s};
  assign addr_inc = addr_ptr_q + ADDR_W'(1);   // natural modulo wrap, no page wrap

  // ACK slots are two SCL falls long: the first fall after the 8th bit starts
  // pulling SDA low, the next fall releases it. sda_oe_q tells them apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      addr_ptr_q <= '0;
    end else begin
      wr_pulse_q <= 1'b0;
      // Bus conditions outrank bit-level activity in every state.
      if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (start_det) begin
        // START or repeated START: drop any partial byte, keep the pointer.
        state_q   <= ST_CTRL;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: ;

          ST_CTRL: if (scl_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              if (ctrl_match(shift_in, DEV_ID)) begin
                state_q                  <= ST_ACK_CTRL;
                busy_q                   <= 1'b1;
                rw_q                     <= shift_in[0];
                addr_ptr_q[ADDR_W-1:8]   <= shift_in[HI_W:1];
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end

          ST_ACK_CTRL: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
              // Prefetch for a read; pointer high bits were set one byte ago.
              shift_q  <= mem[addr_ptr_q];
            end else if (rw_q) begin
              // Release the ACK and present the MSB on the same low phase.
              sda_oe_q  <= ~shift_q[7];
              bit_cnt_q <= '0;
              state_q   <= ST_RDATA;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_ADDR;
            end
          end

          ST_ADDR: if (scl_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q        <= '0;
              addr_ptr_q[7:0]  <= shift_in;
              state_q          <= ST_ACK_ADDR;
            end
          end

          ST_ACK_ADDR: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WDATA;
            end
          end

          ST_WDATA: if (scl_rise) begin
            shift_q   <= shift_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              state_q   <= ST_ACK_WDATA;
            end
          end

          ST_ACK_WDATA: if (scl_fall) begin
            if (!sda_oe_q) begin
              // Full byte received: commit it and advance.
              sda_oe_q   <= 1'b1;
              wr_pulse_q <= 1'b1;
              wr_addr_q  <= addr_ptr_q;
              wr_data_q  <= shift_q;
              addr_ptr_q <= addr_inc;
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= ST_WDATA;
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;          // hand SDA to the master for ACK/NACK
                state_q  <= ST_RACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end

          ST_RACK: begin
            if (scl_rise) begin
              addr_ptr_q <= addr_inc;
              if (sda_s) begin
                state_q <= ST_IDLE;        // NACK ends the read
                busy_q  <= 1'b0;
              end else begin
                shift_q <= mem[addr_inc];
              end
            end else if (scl_fall) begin
              // Only reachable after an ACK; NACK has already left this state.
              sda_oe_q  <= ~shift_q[7];
              bit_cnt_q <= '0;
              state_q   <= ST_RDATA;
            end
          end

          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst and a
  // reset branch would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (wr_pulse_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign busy_o     = busy_q;
  assign wr_pulse_o = wr_pulse_q;
  assign addr_ptr_o = addr_ptr_q;

endmodule
